// File: rtl/upg_frame_loader_if.sv
// Byte-stream input and memory-programming write bus of the UPG frame loader.
// The slave modport is the loader; the master modport is the UART side and memory side.
interface upg_frame_loader_if #(
    parameter int ADDR_W = 14
) ();
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              upg_wen_o;
    logic [ADDR_W-1:0] upg_addr_o;
    logic [31:0]       upg_data_o;
    logic              upg_target_o;
    logic              upg_done_o;
    logic              err_o;
    logic              busy_o;

    modport master (
        output rx_valid_i,
        output rx_data_i,
        input  upg_wen_o,
        input  upg_addr_o,
        input  upg_data_o,
        input  upg_target_o,
        input  upg_done_o,
        input  err_o,
        input  busy_o
    );

    modport slave (
        input  rx_valid_i,
        input  rx_data_i,
        output upg_wen_o,
        output upg_addr_o,
        output upg_data_o,
        output upg_target_o,
        output upg_done_o,
        output err_o,
        output busy_o
    );
endinterface

// File: rtl/upg_frame_loader.sv
// Boot-time loader: parses framed UART segments (sync, target, count, payload, XOR checksum)
// and emits one registered memory write per assembled little-endian 32-bit word.
module upg_frame_loader #(
    parameter int         ADDR_W    = 14,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1_000_000
) (
    input logic               upg_clk_i,
    input logic               upg_rst_i,
    upg_frame_loader_if.slave bus
);
    localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT);
    localparam logic [16:0]       MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0]   ONE_W     = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TARGET = 3'd1,
        S_LEN0   = 3'd2,
        S_LEN1   = 3'd3,
        S_DATA   = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   waddr_q, waddr_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic              seg_tgt_q, seg_tgt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              tgt_q, tgt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              rx_valid_s;
    logic [7:0]        rx_data_s;
    logic              in_frame_s;
    logic              timeout_s;
    logic [16:0]       count_s;
    logic              len_bad_s;
    logic              last_byte_s;
    logic              last_word_s;

    assign rx_valid_s  = bus.rx_valid_i;
    assign rx_data_s   = bus.rx_data_i;
    assign in_frame_s  = (state_q == S_TARGET) || (state_q == S_LEN0) || (state_q == S_LEN1)
                      || (state_q == S_DATA)   || (state_q == S_CHK);
    // A byte in the terminal-count cycle wins over the timeout.
    assign timeout_s   = in_frame_s && !rx_valid_s && (tcnt_q == TCNT_MAX);
    assign count_s     = {1'b0, rx_data_s, len_lo_q};
    assign len_bad_s   = (count_s == 17'd0) || (count_s > MAX_WORDS);
    assign last_byte_s = (lane_q == 2'd3);
    assign last_word_s = (waddr_q == (nwords_q - ONE_W));

    // State register.
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (timeout_s) begin
            state_d = S_ERR;
        end else if (rx_valid_s) begin
            case (state_q)
                S_IDLE:   state_d = (rx_data_s == SYNC_BYTE) ? S_TARGET : S_IDLE;
                S_TARGET: begin
                    if ((rx_data_s == 8'h00) || (rx_data_s == 8'h01)) begin
                        state_d = S_LEN0;
                    end else if (rx_data_s == 8'hFF) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
                S_LEN0:   state_d = S_LEN1;
                S_LEN1:   state_d = len_bad_s ? S_ERR : S_DATA;
                S_DATA:   state_d = (last_byte_s && last_word_s) ? S_CHK : S_DATA;
                S_CHK:    state_d = (rx_data_s == csum_q) ? S_IDLE : S_ERR;
                S_DONE:   state_d = S_DONE;
                S_ERR:    state_d = S_ERR;
                default:  state_d = S_ERR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath and output next values.
    always_comb begin
        lane_d    = lane_q;
        word_d    = word_q;
        waddr_d   = waddr_q;
        nwords_d  = nwords_q;
        csum_d    = csum_q;
        len_lo_d  = len_lo_q;
        seg_tgt_d = seg_tgt_q;
        wen_d     = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        tgt_d     = tgt_q;
        tcnt_d    = (in_frame_s && !rx_valid_s) ? (tcnt_q + TCNT_W'(1)) : '0;
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
        busy_d    = (state_d == S_TARGET) || (state_d == S_LEN0) || (state_d == S_LEN1)
                 || (state_d == S_DATA)   || (state_d == S_CHK);
        if (rx_valid_s) begin
            case (state_q)
                S_IDLE: begin
                    lane_d = 2'd0;
                    csum_d = 8'h00;
                end
                S_TARGET: seg_tgt_d = rx_data_s[0];
                S_LEN0:   len_lo_d  = rx_data_s;
                S_LEN1: begin
                    nwords_d = count_s[ADDR_W:0];
                    waddr_d  = '0;
                    lane_d   = 2'd0;
                    csum_d   = 8'h00;
                end
                S_DATA: begin
                    csum_d = csum_q ^ rx_data_s;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0:    word_d[7:0]   = rx_data_s;
                        2'd1:    word_d[15:8]  = rx_data_s;
                        2'd2:    word_d[23:16] = rx_data_s;
                        default: begin
                            wen_d   = 1'b1;
                            data_d  = {rx_data_s, word_q};
                            addr_d  = waddr_q[ADDR_W-1:0];
                            tgt_d   = seg_tgt_q;
                            waddr_d = waddr_q + ONE_W;
                        end
                    endcase
                end
                default: lane_d = lane_q;
            endcase
        end else begin
            lane_d = lane_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            lane_q    <= 2'd0;
            word_q    <= 24'd0;
            waddr_q   <= '0;
            nwords_q  <= '0;
            csum_q    <= 8'h00;
            len_lo_q  <= 8'h00;
            seg_tgt_q <= 1'b0;
            tcnt_q    <= '0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= 32'd0;
            tgt_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            lane_q    <= lane_d;
            word_q    <= word_d;
            waddr_q   <= waddr_d;
            nwords_q  <= nwords_d;
            csum_q    <= csum_d;
            len_lo_q  <= len_lo_d;
            seg_tgt_q <= seg_tgt_d;
            tcnt_q    <= tcnt_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tgt_q     <= tgt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.upg_wen_o    = wen_q;
    assign bus.upg_addr_o   = addr_q;
    assign bus.upg_data_o   = data_q;
    assign bus.upg_target_o = tgt_q;
    assign bus.upg_done_o   = done_q;
    assign bus.err_o        = err_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_upg_frame_loader.sv
// Self-checking bench for upg_frame_loader: directed and random byte streams compared
// against a frame-level parser of the same stream kept in the bench.
module tb_upg_frame_loader;
    typedef logic [7:0] byte_t;
    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        tgt;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    byte_t stim_q[$];
    wr_t   exp_q[$];
    wr_t   obs_q[$];
    bit    exp_done;
    bit    exp_err;

    upg_frame_loader_if #(.ADDR_W(14)) bus ();

    upg_frame_loader #(
        .ADDR_W   (14),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (16)
    ) dut (
        .upg_clk_i(clk),
        .upg_rst_i(rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Write-bus monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.upg_wen_o === 1'b1) begin
            obs_q.push_back('{int'(bus.upg_addr_o), bus.upg_data_o, bus.upg_target_o});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input byte_t b, input int gap);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i = b;
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_all(input int max_gap);
        foreach (stim_q[i]) send(stim_q[i], (max_gap == 0) ? 0 : int'($urandom_range(max_gap)));
    endtask

    task automatic add_frame(input byte_t tgt, input byte_t pl[$], input bit bad);
        byte_t x = 8'h00;
        int    n = pl.size() / 4;
        stim_q.push_back(8'hA5);
        stim_q.push_back(tgt);
        stim_q.push_back(n[7:0]);
        stim_q.push_back(n[15:8]);
        foreach (pl[i]) begin
            x ^= pl[i];
            stim_q.push_back(pl[i]);
        end
        stim_q.push_back(bad ? (x ^ 8'h5A) : x);
    endtask

    // Reference: walk the byte stream frame by frame and list the words that must be written.
    task automatic model_run();
        int          i = 0;
        int          cnt;
        byte_t       t;
        byte_t       x;
        logic [31:0] w;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err = 1'b0;
        while (i < stim_q.size() && !exp_done && !exp_err) begin
            if (stim_q[i] != 8'hA5) begin
                i++;
                continue;
            end
            t = stim_q[i+1];
            i += 2;
            if (t == 8'hFF) begin
                exp_done = 1'b1;
                continue;
            end
            if (t > 8'h01) begin
                exp_err = 1'b1;
                continue;
            end
            cnt = int'({stim_q[i+1], stim_q[i]});
            i += 2;
            if (cnt == 0 || cnt > 16384) begin
                exp_err = 1'b1;
                continue;
            end
            x = 8'h00;
            for (int k = 0; k < cnt; k++) begin
                w = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
                x ^= stim_q[i] ^ stim_q[i+1] ^ stim_q[i+2] ^ stim_q[i+3];
                exp_q.push_back('{k, w, t[0]});
                i += 4;
            end
            if (stim_q[i] != x) exp_err = 1'b1;
            i++;
        end
    endtask

    task automatic compare(input string tag);
        int n;
        repeat (3) @(negedge clk);
        model_run();
        check({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.addr%0d", tag, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check($sformatf("%s.data%0d", tag, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
            check($sformatf("%s.tgt%0d", tag, i), 64'(obs_q[i].tgt), 64'(exp_q[i].tgt));
        end
        check({tag, ".done"}, 64'(bus.upg_done_o), 64'(exp_done));
        check({tag, ".err"}, 64'(bus.err_o), 64'(exp_err));
        check({tag, ".busy"}, 64'(bus.busy_o), 64'(!exp_done && !exp_err));
    endtask

    task automatic start_test();
        do_reset();
        stim_q.delete();
        obs_q.delete();
    endtask

    initial begin
        byte_t pl[$];
        int    nseg;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i = 8'h00;

        // Reset state.
        start_test();
        check("rst.wen", 64'(bus.upg_wen_o), 64'd0);
        check("rst.addr", 64'(bus.upg_addr_o), 64'd0);
        check("rst.data", 64'(bus.upg_data_o), 64'd0);
        check("rst.tgt", 64'(bus.upg_target_o), 64'd0);
        check("rst.done", 64'(bus.upg_done_o), 64'd0);
        check("rst.err", 64'(bus.err_o), 64'd0);
        check("rst.busy", 64'(bus.busy_o), 64'd0);

        // Instruction segment, two words, then end-of-session.
        start_test();
        pl = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        add_frame(8'h00, pl, 1'b0);
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'hFF);
        send_all(3);
        compare("instr");
        if (obs_q.size() == 2) begin
            check("instr.w0", 64'(obs_q[0].data), 64'h12345678);
            check("instr.w1", 64'(obs_q[1].data), 64'hDEADBEEF);
        end else begin
            check("instr.size", 64'(obs_q.size()), 64'd2);
        end

        // Data segment, N=3, one byte every cycle.
        start_test();
        pl.delete();
        for (int i = 0; i < 12; i++) pl.push_back(byte_t'($urandom));
        add_frame(8'h01, pl, 1'b0);
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'hFF);
        send_all(0);
        compare("data_b2b");

        // Bad checksum, later end-of-session must be ignored.
        start_test();
        stim_q = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'hA5, 8'hFF};
        send_all(2);
        compare("badchk");

        // Protocol errors and leading garbage.
        start_test();
        stim_q = '{8'hA5, 8'h07, 8'hA5, 8'hFF};
        send_all(1);
        compare("tgt07");
        start_test();
        stim_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hFF};
        send_all(1);
        compare("cnt0");
        start_test();
        stim_q = '{8'hA5, 8'h00, 8'h01, 8'h40, 8'hA5, 8'hFF};
        send_all(1);
        compare("cnt4001");
        start_test();
        stim_q = '{8'h00, 8'hFF, 8'h3C};
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        add_frame(8'h01, pl, 1'b0);
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'hFF);
        send_all(2);
        compare("garbage");

        // Timeout: error exactly 17 edges after the last accepted byte.
        start_test();
        stim_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        send_all(0);
        repeat (16) @(negedge clk);
        check("tmo.err_early", 64'(bus.err_o), 64'd0);
        check("tmo.busy", 64'(bus.busy_o), 64'd1);
        @(negedge clk);
        check("tmo.err", 64'(bus.err_o), 64'd1);
        check("tmo.busy_off", 64'(bus.busy_o), 64'd0);

        // Gaps of 15 and 16 idle cycles are tolerated (byte wins at terminal count).
        start_test();
        send(8'hA5, 15);
        send(8'h00, 16);
        send(8'h01, 15);
        send(8'h00, 16);
        stim_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88, 8'h44};
        for (int i = 4; i < 9; i++) send(stim_q[i], (i % 2 == 0) ? 15 : 16);
        compare("gap15_16");

        // Reset in the middle of DATA, then a clean frame.
        start_test();
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h99, 0);
        send(8'h88, 0);
        do_reset();
        pl = '{8'hC0, 8'hDE, 8'h0D, 8'hF0, 8'h10, 8'h32, 8'h54, 8'h76};
        add_frame(8'h00, pl, 1'b0);
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'hFF);
        send_all(1);
        compare("rst_mid");

        // Random multi-segment sessions.
        for (int s = 0; s < 8; s++) begin
            start_test();
            nseg = int'($urandom_range(1, 3));
            for (int g = 0; g < nseg; g++) begin
                for (int j = 0; j < int'($urandom_range(2)); j++) begin
                    byte_t gb = byte_t'($urandom);
                    stim_q.push_back((gb == 8'hA5) ? 8'h00 : gb);
                end
                pl.delete();
                for (int j = 0; j < 4 * int'($urandom_range(1, 4)); j++) pl.push_back(byte_t'($urandom));
                add_frame(byte_t'($urandom_range(1)), pl, ($urandom_range(4) == 0));
            end
            stim_q.push_back(8'hA5);
            stim_q.push_back(8'hFF);
            send_all(4);
            compare($sformatf("rand%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
